// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall bus encodings, controller
// state codes and the stall priority encoder.
package pipe_ctrl_pkg;

   localparam int unsigned StallW = 6;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; a held stage also holds all older stages
   localparam logic [StallW-1:0] StallNone = 6'b000000;
   localparam logic [StallW-1:0] StallIf   = 6'b000011;
   localparam logic [StallW-1:0] StallId   = 6'b000111;
   localparam logic [StallW-1:0] StallEx   = 6'b001111;
   localparam logic [StallW-1:0] StallMem  = 6'b011111;

   typedef enum logic [0:0] {
      CtrlRun   = 1'b0,
      CtrlFlush = 1'b1
   } ctrl_state_e;

   // The youngest requesting stage wins: mem over ex over id over if
   function automatic logic [StallW-1:0] stall_encode(input logic req_if,
                                                      input logic req_id,
                                                      input logic req_ex,
                                                      input logic req_mem);
      logic [StallW-1:0] enc;
      enc = StallNone;
      if (req_mem) begin
         enc = StallMem;
      end else if (req_ex) begin
         enc = StallEx;
      end else if (req_id) begin
         enc = StallId;
      end else if (req_if) begin
         enc = StallIf;
      end
      return enc;
   endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturates at WDOG_LIMIT and
// raises a sticky timeout flag that only reset or a new flush request clears.
module pipe_ctrl_stall_wdog #(
   parameter int unsigned WDOG_LIMIT = 256,
   parameter int unsigned WDOG_W     = 9
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stall_i,
   input  logic in_flush_i,
   input  logic flush_req_i,
   output logic stall_timeout_o
);

   localparam logic [WDOG_W-1:0] Limit = WDOG_W'(WDOG_LIMIT);

   logic [WDOG_W-1:0] cnt_q, cnt_d;
   logic              timeout_q, timeout_d;

   // Next count and flag; flag set on the edge the count reaches the limit
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (in_flush_i || !stall_i) begin
         cnt_d = '0;
      end else if (cnt_q != Limit) begin
         cnt_d = cnt_q + WDOG_W'(1);
      end
      if (flush_req_i) begin
         timeout_d = 1'b0;
      end else if (cnt_d == Limit) begin
         timeout_d = 1'b1;
      end
   end

   // Counter and sticky flag registers, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests into one stall vector and turns
// exception flush requests into a timed flush window followed by a PC reload.
// Define PIPE_WDOG_EN to build the stall watchdog; otherwise stall_timeout is 0.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_LEN  = 2,
   parameter int unsigned WDOG_LIMIT = 256,
   parameter int unsigned WDOG_W     = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              stallreq_mem,
   input  logic              flush_req,
   input  logic [31:0]       flush_pc,
   output logic [StallW-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              pc_load,
   output logic              stall_timeout
);

   localparam int unsigned   CntW      = 4;
   localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_LEN - 1);

   if (FLUSH_LEN < 1 || FLUSH_LEN > 15 || (64'd1 << WDOG_W) <= 64'(WDOG_LIMIT)) begin : g_bad_cfg
      $error("pipe_ctrl: FLUSH_LEN must be 1..15 and 2**WDOG_W must exceed WDOG_LIMIT");
   end

   ctrl_state_e     state_q;
   logic [CntW-1:0] flush_cnt_q;
   logic            flush_q;
   logic [31:0]     new_pc_q;

   // Stall vector: live requests in RUN, forced to none in FLUSH and while in reset
   always_comb begin
      stall = StallNone;
      if (rst && state_q == CtrlRun) begin
         stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      end
   end

   // Reload on the last flush cycle unless a newer exception restarts the window
   assign pc_load = (state_q == CtrlFlush) && (flush_cnt_q == '0) && !flush_req;
   assign flush   = flush_q;
   assign new_pc  = new_pc_q;

   // RUN/FLUSH controller; the latest flush request always owns new_pc
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= CtrlRun;
         flush_q     <= 1'b0;
         flush_cnt_q <= '0;
         new_pc_q    <= ZeroWord;
      end else begin
         unique case (state_q)
            CtrlRun: begin
               if (flush_req) begin
                  state_q     <= CtrlFlush;
                  flush_q     <= 1'b1;
                  flush_cnt_q <= FlushLoad;
                  new_pc_q    <= flush_pc;
               end
            end
            CtrlFlush: begin
               if (flush_req) begin
                  flush_cnt_q <= FlushLoad;
                  new_pc_q    <= flush_pc;
               end else if (flush_cnt_q == '0) begin
                  state_q <= CtrlRun;
                  flush_q <= 1'b0;
               end else begin
                  flush_cnt_q <= flush_cnt_q - CntW'(1);
               end
            end
            default: begin
               state_q <= CtrlRun;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_WDOG_EN
   pipe_ctrl_stall_wdog #(
      .WDOG_LIMIT (WDOG_LIMIT),
      .WDOG_W     (WDOG_W)
   ) u_stall_wdog (
      .clk_i           (clk),
      .rst_ni          (rst),
      .stall_i         (stall != StallNone),
      .in_flush_i      (state_q == CtrlFlush),
      .flush_req_i     (flush_req),
      .stall_timeout_o (stall_timeout)
   );
`else
   assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations and expected
// reload addresses; a monitor on the falling edge pops and compares them.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic        flush_req;
   logic [31:0] flush_pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        pc_load;
   logic        stall_timeout;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          idx;
      logic [5:0]  stall;
      logic        flush;
      logic        pc_load;
      logic        chk_pc;
      logic [31:0] pc;
      logic        timeout;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pc_q[$];
   int          cyc_idx = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .FLUSH_LEN  (2),
      .WDOG_LIMIT (4),
      .WDOG_W     (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_if   (stallreq_if),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .stallreq_mem  (stallreq_mem),
      .flush_req     (flush_req),
      .flush_pc      (flush_pc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .pc_load       (pc_load),
      .stall_timeout (stall_timeout)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, idx, act, expv);
      end
   endtask

   // One cycle of stimulus; req = {mem, ex, id, if}; expectations are for this same cycle
   task automatic cyc(input logic r, input logic [3:0] req, input logic fr,
                      input logic [31:0] fpc, input logic [5:0] e_stall, input logic e_flush,
                      input logic e_pcl, input logic [31:0] e_pc, input logic chk_pc,
                      input logic e_to);
      exp_t e;
      @(posedge clk);
      #1;
      rst          = r;
      stallreq_mem = req[3];
      stallreq_ex  = req[2];
      stallreq_id  = req[1];
      stallreq_if  = req[0];
      flush_req    = fr;
      flush_pc     = fpc;
      cyc_idx++;
      e.idx     = cyc_idx;
      e.stall   = e_stall;
      e.flush   = e_flush;
      e.pc_load = e_pcl;
      e.chk_pc  = chk_pc;
      e.pc      = e_pc;
`ifdef PIPE_WDOG_EN
      e.timeout = e_to;
`else
      e.timeout = 1'b0;
`endif
      exp_q.push_back(e);
      if (e_pcl) pc_q.push_back(e_pc);
   endtask

   // Monitor: per-cycle expectations plus a reload-address scoreboard driven by pc_load
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", e.idx, 32'(stall), 32'(e.stall));
            check("flush", e.idx, 32'(flush), 32'(e.flush));
            check("pc_load", e.idx, 32'(pc_load), 32'(e.pc_load));
            check("stall_timeout", e.idx, 32'(stall_timeout), 32'(e.timeout));
            if (e.chk_pc) check("new_pc_reset", e.idx, new_pc, e.pc);
         end
         if (pc_load === 1'b1) begin
            if (pc_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pc_load_unexpected: got pc_load=1 new_pc=%h, expected no reload",
                        new_pc);
            end else begin
               check("new_pc_reload", cyc_idx, new_pc, pc_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   localparam logic [5:0] S0 = 6'b000000;
   localparam logic [5:0] SM = 6'b011111;
   localparam logic [31:0] Z = 32'h0;

   initial begin
      rst = 1'b0;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b1111;
      flush_req = 1'b1;
      flush_pc  = 32'h1234_5678;
      // Reset held three cycles with every request asserted
      cyc(0, 4'b1111, 1, 32'h12345678, S0,        0, 0, Z, 1, 0);
      cyc(0, 4'b1111, 1, 32'h12345678, S0,        0, 0, Z, 1, 0);
      cyc(0, 4'b1111, 1, 32'h12345678, S0,        0, 0, Z, 1, 0);
      // Priority encoding
      cyc(1, 4'b0110, 0, Z,            6'b001111, 0, 0, Z, 0, 0);
      cyc(1, 4'b0010, 0, Z,            6'b000111, 0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b0001, 0, Z,            6'b000011, 0, 0, Z, 0, 0);
      cyc(1, 4'b1111, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // Flush timing with mem stall asserted throughout
      cyc(1, 4'b1000, 1, 32'hBFC00380, SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            S0,        1, 1, 32'hBFC00380, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // Back-to-back flush: latest address wins, single reload
      cyc(1, 4'b0000, 1, 32'h80000180, S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 1, 32'hBFC00200, S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 1, 32'hBFC00200, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // New flush in the reload cycle cancels that reload
      cyc(1, 4'b0000, 1, 32'h11111110, S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 1, 32'h22222220, S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 1, 32'h22222220, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // Reset mid-flush discards the latched PC
      cyc(1, 4'b0000, 1, 32'h33333330, S0,        0, 0, Z, 0, 0);
      cyc(0, 4'b0000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 1, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // Watchdog: four stalled cycles trip the sticky flag
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 1);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 1);
      // Flush request clears the flag
      cyc(1, 4'b0000, 1, 32'hAAAA0000, S0,        0, 0, Z, 0, 1);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        1, 1, 32'hAAAA0000, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      // 3 stalled, 1 free, 3 stalled: flag stays low
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b1000, 0, Z,            SM,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      cyc(1, 4'b0000, 0, Z,            S0,        0, 0, Z, 0, 0);
      @(negedge clk);
      #1;
      // Every expected reload must have been seen
      check("reloads_outstanding", cyc_idx, 32'(pc_q.size()), 32'd0);
      check("expects_outstanding", cyc_idx, 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
